// File: rtl/video_pkg.sv
// Shared constants, state encoding and blank/sync window decode for the
// NES video timing controller.
package video_pkg;

    localparam logic [9:0] H_ACTIVE    = 10'd256;
    localparam logic [9:0] V_ACTIVE    = 10'd240;
    localparam logic [9:0] H_CROP_HI   = 10'd248;
    localparam logic [9:0] H_CROP_LO   = 10'd10;
    localparam logic [9:0] V_CROP_HI   = 10'd230;
    localparam logic [9:0] V_CROP_LO   = 10'd6;
    localparam logic [9:0] HSYNC_START = 10'd277;
    localparam logic [9:0] HSYNC_END   = 10'd318;
    localparam logic [9:0] VSYNC_START = 10'd245;
    localparam logic [9:0] VSYNC_END   = 10'd254;

    // PPU pre-render line as reported on count_v
    localparam logic [8:0] PRE_RENDER_LINE = 9'd511;

    typedef enum logic [1:0] {
        VT_ACQUIRE,
        VT_TRACK,
        VT_FREE
    } vt_state_e;

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
    } blank_sync_t;

    function automatic blank_sync_t calc_blank_sync(
        input logic [9:0] hc,
        input logic [9:0] vc,
        input logic       crop
    );
        blank_sync_t r;
        if (crop) begin
            r.hblank = (hc > H_CROP_HI) || (hc < H_CROP_LO);
            r.vblank = (vc > V_CROP_HI) || (vc < V_CROP_LO);
        end else begin
            r.hblank = (hc >= H_ACTIVE);
            r.vblank = (vc >= V_ACTIVE);
        end
        r.hsync = (hc >= HSYNC_START) && (hc < HSYNC_END);
        r.vsync = (vc >= VSYNC_START) && (vc < VSYNC_END);
        return r;
    endfunction

endpackage

// File: rtl/video_ce_gen.sv
// Pixel clock-enable generator: a free-running 4-bit phase counter giving
// pix_ce once every 16 clocks and pix_ce_n half a period later.
module video_ce_gen (
    input  logic clk,
    input  logic reset_n,
    output logic pix_ce,
    output logic pix_ce_n
);

    logic [3:0] cnt_q, cnt_d;
    logic       pix_ce_q, pix_ce_d;
    logic       pix_ce_n_q, pix_ce_n_d;

    // Next phase and enable decode
    always_comb begin
        cnt_d      = cnt_q + 4'd1;
        pix_ce_d   = (cnt_q == 4'd0);
        pix_ce_n_d = (cnt_q == 4'd8);
    end

    // Phase counter and registered enables
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            pix_ce_q   <= 1'b0;
            pix_ce_n_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pix_ce_q   <= pix_ce_d;
            pix_ce_n_q <= pix_ce_n_d;
        end
    end

    assign pix_ce   = pix_ce_q;
    assign pix_ce_n = pix_ce_n_q;

endmodule

// File: rtl/video_timing_ctl.sv
// Video timing controller: follows the PPU beam counters while PPU frame
// starts keep arriving and falls back to internal free-running counters
// when they stop, so blanking and sync stay stable downstream.
// Build option VIDEO_TIMING_OVERSCAN_EN enables the hide_overscan crop windows.
module video_timing_ctl
    import video_pkg::*;
#(
    parameter int H_TOTAL     = 341,
    parameter int V_TOTAL     = 262,
    parameter int LOCK_FRAMES = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [8:0] count_h,
    input  logic [8:0] count_v,
    input  logic       hide_overscan,
    output logic       pix_ce,
    output logic       pix_ce_n,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hblank,
    output logic       vblank,
    output logic       hsync,
    output logic       vsync,
    output logic       locked,
    output logic       free_run
);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [2:0] LOCK_CNT = 3'(LOCK_FRAMES);
    localparam blank_sync_t BS_RESET = '{hblank: 1'b1, vblank: 1'b1, hsync: 1'b0, vsync: 1'b0};

    vt_state_e   state_q, state_d;
    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [8:0]  old_count_v_q, old_count_v_d;
    logic [2:0]  miss_q, miss_d;
    logic [2:0]  miss_inc;
    logic        locked_q, locked_d;
    logic        free_run_q, free_run_d;
    blank_sync_t bs_q, bs_d;
    logic        frame_start;
    logic        frame_wrap;
    logic        crop;

    video_ce_gen u_ce_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .pix_ce   (pix_ce),
        .pix_ce_n (pix_ce_n)
    );

`ifdef VIDEO_TIMING_OVERSCAN_EN
    assign crop = hide_overscan;
`else
    logic unused_hide_overscan;
    assign unused_hide_overscan = hide_overscan;
    assign crop = 1'b0;
`endif

    // Position source: PPU counts unless free-running
    always_comb begin
        if (state_q == VT_FREE) begin
            hc = h_q;
            vc = v_q;
        end else begin
            hc = {1'b0, count_h};
            vc = {1'b0, count_v};
        end
    end

    // Frame-start detect, internal counters, miss counter and next state
    always_comb begin
        frame_start   = pix_ce_n && (old_count_v_q == PRE_RENDER_LINE) && (count_v == 9'd0);
        frame_wrap    = 1'b0;
        old_count_v_d = old_count_v_q;
        h_d           = h_q;
        v_d           = v_q;
        miss_d        = miss_q;
        state_d       = state_q;
        miss_inc      = (miss_q == 3'd7) ? miss_q : miss_q + 3'd1;
        if (pix_ce_n) begin
            old_count_v_d = count_v;
            if (frame_start) begin
                h_d = '0;
                v_d = '0;
            end else if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d        = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end

            if (frame_start) begin
                miss_d = '0;
            end else if (frame_wrap) begin
                miss_d = miss_inc;
            end

            case (state_q)
                VT_ACQUIRE, VT_TRACK: begin
                    if (frame_start) begin
                        state_d = VT_TRACK;
                    end else if (frame_wrap && (miss_inc >= LOCK_CNT)) begin
                        state_d = VT_FREE;
                    end
                end
                VT_FREE: begin
                    if (frame_start) begin
                        state_d = VT_TRACK;
                    end
                end
                default: state_d = VT_ACQUIRE;
            endcase

            // Any state change restarts the miss count
            if (state_d != state_q) begin
                miss_d = '0;
            end
        end
    end

    // Status flags and blank/sync decode for the register stage
    always_comb begin
        locked_d   = (state_d == VT_TRACK);
        free_run_d = (state_d == VT_FREE);
        bs_d       = bs_q;
        if (pix_ce) begin
            bs_d = calc_blank_sync(hc, vc, crop);
        end
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= VT_ACQUIRE;
            h_q           <= '0;
            v_q           <= '0;
            old_count_v_q <= '0;
            miss_q        <= '0;
            locked_q      <= 1'b0;
            free_run_q    <= 1'b0;
            bs_q          <= BS_RESET;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            old_count_v_q <= old_count_v_d;
            miss_q        <= miss_d;
            locked_q      <= locked_d;
            free_run_q    <= free_run_d;
            bs_q          <= bs_d;
        end
    end

    assign hblank   = bs_q.hblank;
    assign vblank   = bs_q.vblank;
    assign hsync    = bs_q.hsync;
    assign vsync    = bs_q.vsync;
    assign locked   = locked_q;
    assign free_run = free_run_q;

endmodule

// File: tb/tb_video_timing_ctl.sv
// Testbench for video_timing_ctl. A reduced frame geometry keeps the
// free-run fallback reachable in a short run; blank/sync windows are
// exercised through the PPU count inputs.
module tb_video_timing_ctl;

    localparam int H_T  = 24;
    localparam int V_T  = 10;
    localparam int LOCK = 3;
    localparam int FRAME_UPD = H_T * V_T;

`ifdef VIDEO_TIMING_OVERSCAN_EN
    localparam bit OV_EN = 1'b1;
`else
    localparam bit OV_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [8:0] count_h = 9'd0;
    logic [8:0] count_v = 9'd0;
    logic       hide_overscan = 1'b0;
    logic       pix_ce, pix_ce_n;
    logic [9:0] hc, vc;
    logic       hblank, vblank, hsync, vsync, locked, free_run;

    int checks = 0;
    int errors = 0;
    int ncen   = 0;

    logic [3:0] exp_bs_q[$];
    int         exp_ev_q[$];

    video_timing_ctl #(
        .H_TOTAL    (H_T),
        .V_TOTAL    (V_T),
        .LOCK_FRAMES(LOCK)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .count_h      (count_h),
        .count_v      (count_v),
        .hide_overscan(hide_overscan),
        .pix_ce       (pix_ce),
        .pix_ce_n     (pix_ce_n),
        .hc           (hc),
        .vc           (vc),
        .hblank       (hblank),
        .vblank       (vblank),
        .hsync        (hsync),
        .vsync        (vsync),
        .locked       (locked),
        .free_run     (free_run)
    );

    always #5 clk = ~clk;

    // Number of pix_ce_n update edges seen since time zero
    always @(posedge clk) begin
        if (pix_ce_n) ncen <= ncen + 1;
    end

    function automatic logic [3:0] exp_bs(input int h, input int v, input bit ov);
        bit crop;
        bit hb, vb, hs, vs;
        crop = ov & OV_EN;
        if (crop) begin
            hb = (h > 248) || (h < 10);
            vb = (v > 230) || (v < 6);
        end else begin
            hb = (h >= 256);
            vb = (v >= 240);
        end
        hs = (h >= 277) && (h < 318);
        vs = (v >= 245) && (v < 254);
        return {hb, vb, hs, vs};
    endfunction

    task automatic next_ce_n_neg(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pix_ce_n) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_pix_ce_n: got timeout expected pulse");
    endtask

    task automatic next_ce_neg(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pix_ce) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_pix_ce: got timeout expected pulse");
    endtask

    // Drives 511 then 0 on successive updates; returns just before the event edge
    task automatic inject_frame_start();
        bit ok;
        next_ce_n_neg(ok);
        count_v = 9'd511;
        next_ce_n_neg(ok);
        count_v = 9'd0;
    endtask

    task automatic wait_free(input string name);
        int exp_n;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < (LOCK * FRAME_UPD + 20) * 16; i++) begin
            @(posedge clk);
            #1;
            if (free_run) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (exp_ev_q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue: got empty expected entry", name);
        end else begin
            exp_n = exp_ev_q.pop_front();
            if (!seen) begin
                errors++;
                $display("FAIL %s_timeout: got free_run=0 expected free_run at update %0d", name, exp_n);
            end else if (ncen !== exp_n) begin
                errors++;
                $display("FAIL %s_update: got %0d expected %0d", name, ncen, exp_n);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        int exp_k;
        reset_n = 1'b0;
        count_h = 9'd100;
        count_v = 9'd100;
        hide_overscan = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = {pix_ce, pix_ce_n, hblank, vblank, hsync, vsync, locked, free_run};
        checks++;
        if (got !== 8'b0011_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", got, 8'b0011_0000);
        end
        checks++;
        if (hc !== 10'd100) begin
            errors++;
            $display("FAIL reset_hc: got %0d expected 100", hc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_ev_q.push_back(1);
        exp_ev_q.push_back(17);
        exp_ev_q.push_back(33);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (pix_ce) begin
                checks++;
                if (exp_ev_q.size() == 0) begin
                    errors++;
                    $display("FAIL pix_ce_extra: got pulse at %0d expected none", k);
                end else begin
                    exp_k = exp_ev_q.pop_front();
                    if (k !== exp_k) begin
                        errors++;
                        $display("FAIL pix_ce_cycle: got %0d expected %0d", k, exp_k);
                    end
                end
            end
            checks++;
            if (pix_ce_n !== ((k % 16) == 9)) begin
                errors++;
                $display("FAIL pix_ce_n_cycle%0d: got %0d expected %0d", k, pix_ce_n, ((k % 16) == 9));
            end
            checks++;
            if (hblank !== (k <= 1) || vblank !== (k <= 1)) begin
                errors++;
                $display("FAIL blank_after_reset%0d: got %0d%0d expected %0d%0d", k, hblank, vblank, (k <= 1), (k <= 1));
            end
        end
        checks++;
        if (exp_ev_q.size() != 0) begin
            errors++;
            $display("FAIL pix_ce_missing: got %0d left expected 0", exp_ev_q.size());
            exp_ev_q.delete();
        end
    endtask

    task automatic test_lock();
        logic [8:0] vals [4] = '{9'd5, 9'd200, 9'd300, 9'd511};
        count_h = 9'd5;
        inject_frame_start();
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_before: got %0d expected 0", locked);
        end
        @(posedge clk);
        #1;
        checks++;
        if (locked !== 1'b1 || free_run !== 1'b0) begin
            errors++;
            $display("FAIL lock_after: got locked=%0d free_run=%0d expected 1 0", locked, free_run);
        end
        exp_ev_q.push_back(ncen + LOCK * FRAME_UPD);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            count_h = vals[i];
            #1;
            checks++;
            if (hc !== {1'b0, vals[i]}) begin
                errors++;
                $display("FAIL track_hc: got %0d expected %0d", hc, vals[i]);
            end
        end
    endtask

    task automatic test_blank();
        int  th [10] = '{249, 10, 9, 249, 255, 256, 277, 317, 318, 276};
        int  tv [10] = '{100, 5, 231, 100, 239, 240, 245, 253, 254, 244};
        bit  tov[10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        logic [3:0] e, got;
        bit ok;
        for (int i = 0; i < 10; i++) begin
            next_ce_n_neg(ok);
            count_h = 9'(th[i]);
            count_v = 9'(tv[i]);
            hide_overscan = tov[i];
            exp_bs_q.push_back(exp_bs(th[i], tv[i], tov[i]));
            next_ce_neg(ok);
            @(posedge clk);
            #1;
            got = {hblank, vblank, hsync, vsync};
            e = exp_bs_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL blank_sync h=%0d v=%0d ov=%0d: got %b expected %b", th[i], tv[i], tov[i], got, e);
            end
        end
        hide_overscan = 1'b0;
        count_v = 9'd100;
    endtask

    task automatic test_free();
        int eh, ev;
        bit ok;
        wait_free("free_entry");
        checks++;
        if (locked !== 1'b0 || hc !== 10'd0 || vc !== 10'd0) begin
            errors++;
            $display("FAIL free_start: got locked=%0d hc=%0d vc=%0d expected 0 0 0", locked, hc, vc);
        end
        eh = 0;
        ev = 0;
        for (int i = 0; i < 2 * H_T + 3; i++) begin
            next_ce_n_neg(ok);
            @(posedge clk);
            #1;
            eh++;
            if (eh == H_T) begin
                eh = 0;
                ev = (ev + 1) % V_T;
            end
            checks++;
            if (hc !== 10'(eh) || vc !== 10'(ev)) begin
                errors++;
                $display("FAIL free_count: got %0d,%0d expected %0d,%0d", hc, vc, eh, ev);
            end
        end
    endtask

    task automatic test_recover();
        count_h = 9'd42;
        inject_frame_start();
        checks++;
        if (free_run !== 1'b1) begin
            errors++;
            $display("FAIL recover_before: got %0d expected 1", free_run);
        end
        @(posedge clk);
        #1;
        checks++;
        if (locked !== 1'b1 || free_run !== 1'b0 || hc !== 10'd42) begin
            errors++;
            $display("FAIL recover_after: got locked=%0d free_run=%0d hc=%0d expected 1 0 42", locked, free_run, hc);
        end
        exp_ev_q.push_back(ncen + LOCK * FRAME_UPD);
        @(negedge clk);
        count_v = 9'd100;
        wait_free("refree_entry");
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        bit found;
        int exp_k;
        found = 1'b0;
        for (int i = 0; i < FRAME_UPD * 16 + 100; i++) begin
            @(posedge clk);
            #1;
            if (free_run && hc == 10'd15 && vc == 10'd5) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_position: got hc=%0d vc=%0d expected 15 5", hc, vc);
        end
        count_h = 9'd77;
        #2;
        reset_n = 1'b0;
        #1;
        got = {pix_ce, pix_ce_n, hblank, vblank, hsync, vsync, locked, free_run};
        checks++;
        if (got !== 8'b0011_0000 || hc !== 10'd77) begin
            errors++;
            $display("FAIL mid_reset: got %b hc=%0d expected %b hc=77", got, hc, 8'b0011_0000);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_ev_q.push_back(1);
        exp_ev_q.push_back(17);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (pix_ce) begin
                checks++;
                exp_k = (exp_ev_q.size() != 0) ? exp_ev_q.pop_front() : -1;
                if (k !== exp_k) begin
                    errors++;
                    $display("FAIL mid_pix_ce: got %0d expected %0d", k, exp_k);
                end
            end
        end
        checks++;
        if (locked !== 1'b0 || free_run !== 1'b0 || hc !== 10'd77 || exp_ev_q.size() != 0) begin
            errors++;
            $display("FAIL mid_acquire: got locked=%0d free_run=%0d hc=%0d left=%0d expected 0 0 77 0",
                     locked, free_run, hc, exp_ev_q.size());
            exp_ev_q.delete();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_lock();
        test_blank();
        test_free();
        test_recover();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_ctl.md
# video_timing_ctl

Video timing controller for the NES video path. It generates the pixel clock enables, tracks the PPU beam counters, and detects PPU frame starts. When the PPU stops producing frames, it falls back to free-running internal counters so the downstream scaler/mixer always sees stable blanking and sync. It sits between the PPU (`count_h`/`count_v`) and the palette lookup / video mixer stage.

## Interface
Parameters:
- `H_TOTAL`, 341, dots per line; internal h counter wraps at `H_TOTAL-1`.
- `V_TOTAL`, 262, lines per frame; internal v counter wraps at `V_TOTAL-1`.
- `LOCK_FRAMES`, 3, consecutive internal frames without a PPU frame start before entering FREE (range 1..7).

Ports:
- `clk` in 1: system clock; the single clock of the block.
- `reset_n` in 1: reset, asynchronous, active-low.
- `count_h` in 9: PPU dot counter.
- `count_v` in 9: PPU line counter; pre-render line reads 511.
- `hide_overscan` in 1: crop overscan borders.
- `pix_ce` out 1: pixel enable, 1 `clk` in 16.
- `pix_ce_n` out 1: pixel enable, half-phase (8 `clk` after `pix_ce`).
- `hc` out 10: selected horizontal position.
- `vc` out 10: selected vertical position.
- `hblank` out 1: horizontal blank.
- `vblank` out 1: vertical blank.
- `hsync` out 1: horizontal sync, active high.
- `vsync` out 1: vertical sync, active high.
- `locked` out 1: state is TRACK.
- `free_run` out 1: state is FREE.

## Operation
Enable generation:
- 4-bit `cnt` increments every `clk`.
- `pix_ce` is registered `cnt==0`; `pix_ce_n` is registered `cnt==8`.

Frame-start event:
- Evaluated only on `pix_ce_n`.
- Fires when `old_count_v==511 && count_v==0`.
- `old_count_v` (9 bits) updates on every `pix_ce_n`.

Internal counters `h`, `v` (10 bits), advanced on `pix_ce_n`:
- A frame-start event clears `h` and `v`; the event has priority over wrap.
- Otherwise `h` increments; at `h==H_TOTAL-1` it clears and `v` advances.
- `v` wraps at `V_TOTAL-1`, which counts one internal frame.

FSM, 3 states, updated on `pix_ce_n`:
- ACQUIRE (reset state): `hc/vc` = `count_h/count_v` zero-extended.
  - Frame-start event -> TRACK.
  - After `LOCK_FRAMES` internal frames -> FREE.
- TRACK: `hc/vc` = PPU counts.
  - Frame-start event clears the miss counter.
  - Miss counter reaches `LOCK_FRAMES` -> FREE.
- FREE: `hc/vc` = internal `h/v`.
  - Frame-start event -> TRACK; counters are cleared in the same cycle.
- Miss counter (3 bits, saturating):
  - Cleared on every frame-start event and on any state change.
  - Incremented on each internal frame wrap.

Blanking/sync, registered on `pix_ce` from `hc/vc` (unsigned 10-bit compares):
- Normal: `hblank = hc>=256`; `vblank = vc>=240`.
- Overscan: `hblank = hc>248 || hc<10`; `vblank = vc>230 || vc<6`.
- `hsync = 277<=hc<318`; `vsync = 245<=vc<254`.
- `hide_overscan` is sampled on each `pix_ce`; a change takes effect at the next `pix_ce`, with no glitch between enables.

## Timing
Reset values:
- `cnt`=0, `pix_ce`=`pix_ce_n`=0.
- `h`=`v`=0, `old_count_v`=0, miss=0, state ACQUIRE.
- `hblank`=`vblank`=1, `hsync`=`vsync`=0.
- `locked`=`free_run`=0.

Enable cadence:
- First `pix_ce` is high for the cycle after the first `clk` edge following reset release, then every 16 `clk`.
- `pix_ce_n` is 8 cycles after each `pix_ce`; the two are never simultaneous.

Latency:
- Blank/sync outputs lag `hc/vc` by one `pix_ce` (16 `clk`).
- `locked`/`free_run` are registered and change on the `clk` after the transitioning `pix_ce_n`.

Reset mid-frame forces all reset values immediately (asynchronous), independent of `cnt` phase.

## Configuration
`VIDEO_TIMING_OVERSCAN_EN`:
- Defined: `hide_overscan` selects the overscan crop windows.
- Undefined: `hide_overscan` is ignored and normal windows are always used; the port remains present.

## Structure
- Package `video_pkg`:
  - Constants: `H_ACTIVE`=256, `V_ACTIVE`=240, crop bounds 248/10/230/6, sync windows 277/318 and 245/254.
  - State enum `vt_state_e {VT_ACQUIRE, VT_TRACK, VT_FREE}`.
- Sub-module `video_ce_gen` holds `cnt` and produces `pix_ce`/`pix_ce_n`.

## Test plan
- Reset release, no stimulus -> `pix_ce` pulses at cycles 1, 17, 33; `pix_ce_n` at 9, 25; `hblank`=`vblank`=1 until the first `pix_ce`.
- PPU counts drive 511 -> 0 -> `locked`=1 one `clk` after that `pix_ce_n`; `hc` equals `count_h` thereafter.
- From TRACK, `count_v` frozen at 100 -> after 3 internal frames (3×341×262 `pix_ce_n`) `free_run`=1; `vc` cycles 0..261.
- In FREE, inject 511 -> 0 -> state TRACK, `h`=`v`=0, miss=0 in the same update.
- `hide_overscan`=1 with `VIDEO_TIMING_OVERSCAN_EN` -> `hc`=249 gives `hblank`=1, `hc`=10 gives 0; with the macro undefined, `hc`=249 gives `hblank`=0.
- Assert `reset_n`=0 at `h`=150, `v`=120 in FREE -> outputs return to reset values at once; ACQUIRE resumes after release.
